// File: rtl/gpio_input_conditioner.sv
// GPIO / push-button input front end.
// Two-flop synchronisers on every switch and button line, per-button debounce with
// registered press/release pulses, and a single-entry valid/ready command slot that
// captures the switch bank when the execute button is pressed.
// Optional build macro SW_DEBOUNCE_EN: when defined, every switch bit also passes
// through a debounce counter, so sw_sync lags sw_raw by 2 + DEBOUNCE_CYCLES cycles.

module gpio_input_conditioner #(
  parameter int unsigned SW_WIDTH        = 32,
  parameter int unsigned BTN_WIDTH       = 3,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_WIDTH       = 20,
  parameter int unsigned EXEC_BTN        = 2
) (
  input  logic                 CLOCK_50,
  input  logic                 RESET,
  input  logic [SW_WIDTH-1:0]  sw_raw,
  input  logic [BTN_WIDTH-1:0] btn_raw_n,
  output logic [SW_WIDTH-1:0]  sw_sync,
  output logic [BTN_WIDTH-1:0] btn_level,
  output logic [BTN_WIDTH-1:0] btn_press,
  output logic [BTN_WIDTH-1:0] btn_release,
  output logic                 cmd_valid,
  input  logic                 cmd_ready,
  output logic [SW_WIDTH-1:0]  cmd_sw,
  output logic                 cmd_overrun
);

  // Terminal count: the level flips on the cycle the counter already reads this value.
  localparam logic [CNT_WIDTH-1:0] CntMax = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {StIdle, StFull} state_e;

  // ---------------------------------------------------------------------------
  // Synchronisers
  // ---------------------------------------------------------------------------
  logic [SW_WIDTH-1:0]  sw_meta_q, sw_s2_q;
  logic [BTN_WIDTH-1:0] btn_meta_q, btn_s2_q;
  logic [BTN_WIDTH-1:0] btn_act;

  // Two-flop synchronisers; button flops reset to 1 (released, active-low).
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      sw_meta_q  <= '0;
      sw_s2_q    <= '0;
      btn_meta_q <= '1;
      btn_s2_q   <= '1;
    end else begin
      sw_meta_q  <= sw_raw;
      sw_s2_q    <= sw_meta_q;
      btn_meta_q <= btn_raw_n;
      btn_s2_q   <= btn_meta_q;
    end
  end

  assign btn_act = ~btn_s2_q;

  // ---------------------------------------------------------------------------
  // Button debounce
  // ---------------------------------------------------------------------------
  logic [CNT_WIDTH-1:0] btn_cnt_q [BTN_WIDTH];
  logic [CNT_WIDTH-1:0] btn_cnt_d [BTN_WIDTH];
  logic [BTN_WIDTH-1:0] btn_level_q, btn_level_d;

  // Count consecutive cycles of disagreement; any agreement restarts the count.
  always_comb begin
    for (int i = 0; i < int'(BTN_WIDTH); i++) begin
      btn_cnt_d[i]   = btn_cnt_q[i];
      btn_level_d[i] = btn_level_q[i];
      if (btn_act[i] == btn_level_q[i]) begin
        btn_cnt_d[i] = '0;
      end else if (btn_cnt_q[i] == CntMax) begin
        btn_level_d[i] = ~btn_level_q[i];
        btn_cnt_d[i]   = '0;
      end else begin
        btn_cnt_d[i] = btn_cnt_q[i] + CNT_WIDTH'(1);
      end
    end
  end

  // Debounce state registers.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < int'(BTN_WIDTH); i++) begin
        btn_cnt_q[i] <= '0;
      end
      btn_level_q <= '0;
    end else begin
      for (int i = 0; i < int'(BTN_WIDTH); i++) begin
        btn_cnt_q[i] <= btn_cnt_d[i];
      end
      btn_level_q <= btn_level_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Switch path: debounced or synchronised only
  // ---------------------------------------------------------------------------
  logic [SW_WIDTH-1:0] sw_level;

`ifdef SW_DEBOUNCE_EN
  logic [CNT_WIDTH-1:0] sw_cnt_q [SW_WIDTH];
  logic [CNT_WIDTH-1:0] sw_cnt_d [SW_WIDTH];
  logic [SW_WIDTH-1:0]  sw_level_q, sw_level_d;

  // Same debounce rule as the buttons, applied to each switch bit.
  always_comb begin
    for (int i = 0; i < int'(SW_WIDTH); i++) begin
      sw_cnt_d[i]   = sw_cnt_q[i];
      sw_level_d[i] = sw_level_q[i];
      if (sw_s2_q[i] == sw_level_q[i]) begin
        sw_cnt_d[i] = '0;
      end else if (sw_cnt_q[i] == CntMax) begin
        sw_level_d[i] = ~sw_level_q[i];
        sw_cnt_d[i]   = '0;
      end else begin
        sw_cnt_d[i] = sw_cnt_q[i] + CNT_WIDTH'(1);
      end
    end
  end

  // Switch debounce state registers.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < int'(SW_WIDTH); i++) begin
        sw_cnt_q[i] <= '0;
      end
      sw_level_q <= '0;
    end else begin
      for (int i = 0; i < int'(SW_WIDTH); i++) begin
        sw_cnt_q[i] <= sw_cnt_d[i];
      end
      sw_level_q <= sw_level_d;
    end
  end

  assign sw_level = sw_level_q;
`else
  assign sw_level = sw_s2_q;
`endif

  // ---------------------------------------------------------------------------
  // Edge pulses
  // ---------------------------------------------------------------------------
  logic [BTN_WIDTH-1:0] btn_prev_q;
  logic [BTN_WIDTH-1:0] btn_press_q, btn_press_d;
  logic [BTN_WIDTH-1:0] btn_release_q, btn_release_d;

  // Edge detect against last cycle's level; a bit cannot rise and fall at once.
  always_comb begin
    btn_press_d   = btn_level_q & ~btn_prev_q;
    btn_release_d = ~btn_level_q & btn_prev_q;
  end

  // Pulse and previous-level registers.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      btn_prev_q    <= '0;
      btn_press_q   <= '0;
      btn_release_q <= '0;
    end else begin
      btn_prev_q    <= btn_level_q;
      btn_press_q   <= btn_press_d;
      btn_release_q <= btn_release_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Command slot
  // ---------------------------------------------------------------------------
  state_e              state_q, state_d;
  logic [SW_WIDTH-1:0] cmd_sw_q, cmd_sw_d;
  logic                overrun_q, overrun_d;
  logic                exec_press;

  assign exec_press = btn_press_q[EXEC_BTN];

  // Slot next-state: capture on exec, drain on ready, flag exec into an unaccepted slot.
  always_comb begin
    state_d   = state_q;
    cmd_sw_d  = cmd_sw_q;
    overrun_d = overrun_q;
    unique case (state_q)
      StIdle: begin
        if (exec_press) begin
          cmd_sw_d = sw_level;
          state_d  = StFull;
        end
      end
      StFull: begin
        if (exec_press && cmd_ready) begin
          // Old snapshot leaves as the new one arrives.
          cmd_sw_d = sw_level;
        end else if (exec_press) begin
          overrun_d = 1'b1;
        end else if (cmd_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Slot state registers.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      state_q   <= StIdle;
      cmd_sw_q  <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cmd_sw_q  <= cmd_sw_d;
      overrun_q <= overrun_d;
    end
  end

  assign sw_sync     = sw_level;
  assign btn_level   = btn_level_q;
  assign btn_press   = btn_press_q;
  assign btn_release = btn_release_q;
  assign cmd_valid   = (state_q == StFull);
  assign cmd_sw      = cmd_sw_q;
  assign cmd_overrun = overrun_q;

endmodule

// File: tb/tb_gpio_input_conditioner.sv
// Directed bench for gpio_input_conditioner with DEBOUNCE_CYCLES = 4.
// Inputs change on the falling edge; outputs are sampled on the following falling edge.

module tb_gpio_input_conditioner;

  localparam int unsigned SwW  = 32;
  localparam int unsigned BtnW = 3;
  localparam int unsigned Deb  = 4;
  localparam int unsigned CntW = 3;
  localparam int unsigned Exec = 2;
`ifdef SW_DEBOUNCE_EN
  localparam int SwLat = 2 + Deb;
`else
  localparam int SwLat = 2;
`endif
  localparam int NVec = 40;

  logic            CLOCK_50;
  logic            RESET;
  logic [SwW-1:0]  sw_raw;
  logic [BtnW-1:0] btn_raw_n;
  logic [SwW-1:0]  sw_sync;
  logic [BtnW-1:0] btn_level;
  logic [BtnW-1:0] btn_press;
  logic [BtnW-1:0] btn_release;
  logic            cmd_valid;
  logic            cmd_ready;
  logic [SwW-1:0]  cmd_sw;
  logic            cmd_overrun;

  gpio_input_conditioner #(
    .SW_WIDTH        (SwW),
    .BTN_WIDTH       (BtnW),
    .DEBOUNCE_CYCLES (Deb),
    .CNT_WIDTH       (CntW),
    .EXEC_BTN        (Exec)
  ) dut (
    .CLOCK_50    (CLOCK_50),
    .RESET       (RESET),
    .sw_raw      (sw_raw),
    .btn_raw_n   (btn_raw_n),
    .sw_sync     (sw_sync),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_sw      (cmd_sw),
    .cmd_overrun (cmd_overrun)
  );

  initial CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    logic [BtnW-1:0] btn_n;
    logic [BtnW-1:0] exp_level;
    logic [BtnW-1:0] exp_press;
    logic [BtnW-1:0] exp_release;
  } vec_t;

  vec_t vecs [NVec];
  int   passed = 0;
  int   total  = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(negedge CLOCK_50);
  endtask

  // Drive a new switch word and measure cycles until sw_sync shows it.
  task automatic set_sw(input logic [SwW-1:0] v);
    int n;
    n = 0;
    sw_raw = v;
    while (sw_sync !== v && n < 20) begin
      step();
      n++;
    end
    check("sw_latency", 128'(n), 128'(SwLat));
  endtask

  // Full press-and-release of the execute button, long enough to debounce both edges.
  task automatic exec_press();
    btn_raw_n[Exec] = 1'b0;
    repeat (10) step();
    btn_raw_n[Exec] = 1'b1;
    repeat (10) step();
  endtask

  initial begin
    int n;

    // Glitch on button 1 (3 low cycles) then a 20-cycle press of button 0.
    for (int i = 0; i < NVec; i++) begin
      vecs[i].btn_n       = 3'b111;
      vecs[i].exp_level   = 3'b000;
      vecs[i].exp_press   = 3'b000;
      vecs[i].exp_release = 3'b000;
    end
    for (int i = 0; i < 3; i++) vecs[i].btn_n = 3'b101;
    for (int i = 10; i < 30; i++) vecs[i].btn_n = 3'b110;
    for (int i = 15; i < 35; i++) vecs[i].exp_level = 3'b001;
    vecs[16].exp_press   = 3'b001;
    vecs[36].exp_release = 3'b001;

    RESET     = 1'b1;
    sw_raw    = '0;
    btn_raw_n = '1;
    cmd_ready = 1'b0;
    step();
    step();
    check("reset_state",
          {sw_sync, btn_level, btn_press, btn_release, cmd_valid, cmd_sw, cmd_overrun}, '0);
    RESET = 1'b0;
    step();

    for (int i = 0; i < NVec; i++) begin
      btn_raw_n = vecs[i].btn_n;
      step();
      check($sformatf("vec%0d", i), {btn_level, btn_press, btn_release},
            {vecs[i].exp_level, vecs[i].exp_press, vecs[i].exp_release});
    end

    // Capture and handshake.
    set_sw(32'hA5A5_0F0F);
    exec_press();
    check("cap_valid", 128'(cmd_valid), 128'(1));
    check("cap_sw", 128'(cmd_sw), 128'(32'hA5A5_0F0F));
    cmd_ready = 1'b1;
    step();
    cmd_ready = 1'b0;
    check("cap_drained", 128'(cmd_valid), 128'(0));

    // Overrun: second exec into a full slot.
    set_sw(32'h1111_1111);
    exec_press();
    check("ovr_first_sw", 128'(cmd_sw), 128'(32'h1111_1111));
    check("ovr_first_flag", 128'(cmd_overrun), 128'(0));
    set_sw(32'h2222_2222);
    exec_press();
    check("ovr_sw_held", 128'(cmd_sw), 128'(32'h1111_1111));
    check("ovr_flag", 128'(cmd_overrun), 128'(1));
    check("ovr_valid", 128'(cmd_valid), 128'(1));
    cmd_ready = 1'b1;
    step();
    cmd_ready = 1'b0;
    check("ovr_drained", 128'(cmd_valid), 128'(0));
    check("ovr_sticky", 128'(cmd_overrun), 128'(1));

    // Clear the sticky flag.
    RESET = 1'b1;
    step();
    check("ovr_reset", {cmd_overrun, cmd_valid, sw_sync}, '0);
    RESET = 1'b0;
    step();

    // Back-to-back: exec pulse coincides with cmd_ready while full.
    set_sw(32'h3333_3333);
    exec_press();
    check("b2b_first_sw", 128'(cmd_sw), 128'(32'h3333_3333));
    set_sw(32'h4444_4444);
    btn_raw_n[Exec] = 1'b0;
    n = 0;
    while (!btn_press[Exec] && n < 20) begin
      step();
      n++;
    end
    check("b2b_press_lat", 128'(n), 128'(2 + Deb + 1));
    cmd_ready = 1'b1;
    step();
    cmd_ready = 1'b0;
    check("b2b_valid", 128'(cmd_valid), 128'(1));
    check("b2b_sw", 128'(cmd_sw), 128'(32'h4444_4444));
    check("b2b_overrun", 128'(cmd_overrun), 128'(0));
    btn_raw_n[Exec] = 1'b1;
    repeat (10) step();

    // Asynchronous reset in the middle of a button-0 debounce count.
    btn_raw_n[0] = 1'b0;
    repeat (3) step();
    #5;
    RESET = 1'b1;
    #1;
    check("async_reset",
          {sw_sync, btn_level, btn_press, btn_release, cmd_valid, cmd_sw, cmd_overrun}, '0);
    @(negedge CLOCK_50);
    RESET = 1'b0;
    n = 0;
    while (!btn_level[0] && n < 20) begin
      step();
      n++;
    end
    check("held_level_lat", 128'(n), 128'(2 + Deb));
    step();
    check("held_press", 128'(btn_press), 128'(3'b001));
    btn_raw_n[0] = 1'b1;
    repeat (10) step();

    set_sw(32'hCAFE_BABE);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
